// File: rtl/dio_test_sequencer.sv
// dio_test_sequencer: host-side driver for the DIO loopback tester.
// Sends one settings word, drains status during a settle window, accumulates
// mismatch results over a dwell window, then sends a mode-off word and
// latches pass/fail.
// Optional build macro: DIO_SEQ_SWEEP_EN (runs mode 1 then mode 2 per start,
// adds the sweep_leg output).
module dio_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned DWELL_CYCLES  = 65536,
  parameter logic [7:0]  CLOCK_DIV     = 8'd99,
  parameter logic [7:0]  OUT_PHASE     = 8'd50
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode_sel,
  output logic [31:0] dio_settings_tdata,
  output logic        dio_settings_tvalid,
  input  logic        dio_settings_tready,
  input  logic [31:0] dio_counter_status_tdata,
  input  logic        dio_counter_status_tvalid,
  output logic        dio_counter_status_tready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        cfg_error,
  output logic        aborted,
`ifdef DIO_SEQ_SWEEP_EN
  output logic        sweep_leg,
`endif
  output logic [15:0] fail_mask,
  output logic [15:0] error_count
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CFG, S_SETTLE, S_DWELL, S_SEND_OFF, S_FINISH
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     mode_q, mode_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           cfg_error_q, cfg_error_d;
  logic           aborted_q, aborted_d;
  logic [15:0]    fail_mask_q, fail_mask_d;
  logic [15:0]    error_count_q, error_count_d;
`ifdef DIO_SEQ_SWEEP_EN
  logic           leg_q, leg_d;
`endif

  logic [1:0] rst_sync_q;
  logic       rst_n;
  logic       st_beat;
  logic [15:0] st_mask;
  logic       unused_ok;

  // Reset asserts immediately but releases two clocks after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

`ifdef DIO_SEQ_SWEEP_EN
  assign unused_ok = ^{dio_counter_status_tdata[31:18], mode_sel};
`else
  assign unused_ok = ^dio_counter_status_tdata[31:18];
`endif

  // A stop in SEND_CFG withdraws the pending config beat in the same cycle.
  assign dio_settings_tvalid       = ((state_q == S_SEND_CFG) && !stop) || (state_q == S_SEND_OFF);
  assign dio_settings_tdata        = (state_q == S_SEND_CFG) ? {14'b0, mode_q, OUT_PHASE, CLOCK_DIV} :
                                     (state_q == S_SEND_OFF) ? {14'b0, 2'b00, OUT_PHASE, CLOCK_DIV} :
                                     32'h0;
  assign dio_counter_status_tready = (state_q == S_SETTLE) || (state_q == S_DWELL);
  assign st_beat                   = dio_counter_status_tvalid && dio_counter_status_tready;
  assign st_mask                   = dio_counter_status_tdata[15:0];

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign cfg_error   = cfg_error_q;
  assign aborted     = aborted_q;
  assign fail_mask   = fail_mask_q;
  assign error_count = error_count_q;
`ifdef DIO_SEQ_SWEEP_EN
  assign sweep_leg   = leg_q;
`endif

  // Next-state and result-register logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    cfg_error_d   = cfg_error_q;
    aborted_d     = aborted_q;
    fail_mask_d   = fail_mask_q;
    error_count_d = error_count_q;
`ifdef DIO_SEQ_SWEEP_EN
    leg_d         = leg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef DIO_SEQ_SWEEP_EN
          mode_d        = 2'd1;
          leg_d         = 1'b0;
          fail_mask_d   = '0;
          error_count_d = '0;
          pass_d        = 1'b0;
          cfg_error_d   = 1'b0;
          aborted_d     = 1'b0;
          busy_d        = 1'b1;
          state_d       = S_SEND_CFG;
`else
          if (mode_sel != 2'd0) begin
            mode_d        = mode_sel;
            fail_mask_d   = '0;
            error_count_d = '0;
            pass_d        = 1'b0;
            cfg_error_d   = 1'b0;
            aborted_d     = 1'b0;
            busy_d        = 1'b1;
            state_d       = S_SEND_CFG;
          end else begin
            cfg_error_d = 1'b1;
            state_d     = S_FINISH;
          end
`endif
        end
      end
      S_SEND_CFG: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = S_SEND_OFF;
        end else if (dio_settings_tready) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = S_SEND_OFF;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_DWELL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DWELL: begin
        if (st_beat) begin
          fail_mask_d = fail_mask_q | st_mask;
          if ((st_mask != 16'h0) && (error_count_q != 16'hFFFF))
            error_count_d = error_count_q + 16'd1;
          if (dio_counter_status_tdata[16] || dio_counter_status_tdata[17])
            cfg_error_d = 1'b1;
        end
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = S_SEND_OFF;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = S_SEND_OFF;
`ifdef DIO_SEQ_SWEEP_EN
          if (!leg_q) begin
            leg_d   = 1'b1;
            mode_d  = 2'd2;
            state_d = S_SEND_CFG;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND_OFF: begin
        if (dio_settings_tready) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (fail_mask_q == 16'h0) && !cfg_error_q && !aborted_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mode_q        <= 2'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      cfg_error_q   <= 1'b0;
      aborted_q     <= 1'b0;
      fail_mask_q   <= '0;
      error_count_q <= '0;
`ifdef DIO_SEQ_SWEEP_EN
      leg_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      cfg_error_q   <= cfg_error_d;
      aborted_q     <= aborted_d;
      fail_mask_q   <= fail_mask_d;
      error_count_q <= error_count_d;
`ifdef DIO_SEQ_SWEEP_EN
      leg_q         <= leg_d;
`endif
    end
  end

endmodule
